// File: rtl/edge_detector_bank.sv
// edge_detector_bank: per-channel synchroniser, debouncer and mode-selected edge flags with sticky pending bits
module edge_detector_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   detected,
  output logic [CHANNELS-1:0]   pending,
  output logic                  any_pending
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CHANNELS-1:0] s;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock) begin
        for (int k = 0; k < SYNC_STAGES; k++)
          sync_q[k] <= reset ? '0 : (k == 0) ? in : sync_q[(k == 0) ? 0 : k - 1];
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          level_q, det_q, pend_q, accept, det_next;
      assign accept   = (s[c] != level_q) && (cnt == CW'(DEBOUNCE - 1));
      assign det_next = accept & (s[c] ? mode[2*c] : mode[2*c+1]);
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt     <= '0;
          level_q <= 1'b0;
          det_q   <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          cnt     <= (s[c] == level_q || accept) ? '0 : cnt + 1'b1;
          level_q <= accept ? s[c] : level_q;
          det_q   <= det_next;
          pend_q  <= det_next | (pend_q & ~clear[c]);
        end
      end
      assign level[c]    = level_q;
      assign detected[c] = det_q;
      assign pending[c]  = pend_q;
    end
  endgenerate
  assign any_pending = |pending;
endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Multi-channel, parametrised edge detector. Each channel synchronises an asynchronous input, debounces it, and flags rising, falling or both edges per a runtime mode. Each flag is a one-cycle pulse plus a sticky pending bit. Sits between board-level inputs (buttons, switches, external strobes) and the processor's interrupt/status logic.

## Interface

Parameters:
- CHANNELS, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (0..4; 0 = input used directly)
- DEBOUNCE, 1, consecutive post-sync cycles a new value must persist before acceptance (≥1; 1 = no filtering)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in  in  CHANNELS  raw channel inputs, may be asynchronous
- mode  in  2*CHANNELS  channel i uses mode[2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clear  in  CHANNELS  write-1-to-clear for pending[i]
- level  out  CHANNELS  filtered (synchronised, debounced) level
- detected  out  CHANNELS  one-cycle pulse on an enabled edge
- pending  out  CHANNELS  sticky edge flag
- any_pending  out  1  OR of pending

## Operation

- Synchroniser: shift chain of SYNC_STAGES flops per channel; s[i] = last stage (or in[i] when SYNC_STAGES=0).
- Debounce, per channel: counter cnt[i], width $clog2(DEBOUNCE+1).
  - If s[i] == level[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: level[i] <= s[i], cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any cycle with s == level restarts the count, so glitches shorter than DEBOUNCE cycles are discarded.
- Edge detect: registered, computed from the same update that changes level.
  - rise = level changing 0→1; fall = level changing 1→0.
  - detected[i] <= (rise & mode[2i]) | (fall & mode[2i+1]).
- Pending: pending[i] <= detected_next[i] | (pending[i] & ~clear[i]).
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Clearing an already-0 bit has no effect.
- any_pending is combinational OR of the pending registers.
- Mode changes apply from the next edge evaluation. They do not affect level, the counters, or existing pending bits. Mode 00 still tracks level.
- Channels are fully independent; no cross-channel priority.

## Timing

- Reset: sync stages, level, cnt, detected and pending all 0; any_pending 0.
  - After reset, an input already held at 1 produces a rising edge (level resets to 0).
- Latency: count the first rising edge that samples the new in value as edge 1. level and detected change after edge SYNC_STAGES+DEBOUNCE.
  - Defaults: 3 edges.
  - pending rises on the same edge as detected.
- detected is high for exactly one cycle per accepted level change. Back-to-back changes are at least DEBOUNCE cycles apart.
- Reset asserted mid-debounce or mid-sync discards all in-flight state. It overrides clear and new edges in that cycle.
- clear takes effect on the next edge: pending reads 0 in the following cycle, unless a new edge sets it on that same edge.

## Test plan

- CHANNELS=4, SYNC_STAGES=2, DEBOUNCE=3, mode=01 for ch0. Drive in[0] 0→1 and hold. Required: level[0] and detected[0] go high after edge 5. detected[0] stays high one cycle. pending[0]=1 and any_pending=1 from the same edge.
- Same config: pulse in[0] high for 2 cycles, then low. Required: level[0], detected[0] and pending[0] stay 0. Then a 3-cycle pulse: level[0] high for 3 cycles, one rising pulse.
- Mode sweep on ch1 with DEBOUNCE=1: toggle in[1] 0→1→0 with mode 01, 10, 11, 00 in turn. Required pulses: rising only; falling only; both; none. level[1] tracks in every case.
- Pending clear race: assert clear[2] on the same edge detected[2] fires. Required: pending[2] stays 1. clear[2] one cycle later → pending[2]=0, any_pending=0 if no other bits set.
- Reset mid-operation: hold in[3]=1, assert reset for 1 cycle after edge 3 (before acceptance). Required: all outputs 0 during and after reset. Rising pulse occurs 5 edges after reset deasserts.
- Independence: change all 4 inputs on the same cycle with mode=11. Required: 4 simultaneous detected pulses, and pending=4'b1111.
